// File: rtl/tt_accum_pkg.sv
// Shared types for the multi-channel accumulator: command encoding,
// output-buffer state and the command field width.
package tt_accum_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/tt_accum_alu.sv
// Combinational accumulator datapath: computes the new channel value and
// its out-of-range flag, saturating or wrapping depending on SAT.
module tt_accum_alu
    import tt_accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAT   = 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH+1:0] sumWide;
    logic [WIDTH+1:0] diffWide;

    // Two guard bits: a set top bit marks a negative SUB result, any set
    // guard bit marks an ADD result above the representable maximum.
    assign sumWide  = {2'b00, acc} + {2'b00, a} + {2'b00, b};
    assign diffWide = {2'b00, acc} - {2'b00, a};

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_LOAD: begin
                result = a;
            end
            OP_ADD: begin
                ovf    = |sumWide[WIDTH+1:WIDTH];
                result = (ovf && (SAT != 0)) ? '1 : sumWide[WIDTH-1:0];
            end
            OP_SUB: begin
                ovf    = diffWide[WIDTH+1];
                result = (ovf && (SAT != 0)) ? '0 : diffWide[WIDTH-1:0];
            end
            default: begin
                result = '0;
            end
        endcase
    end

endmodule

// File: rtl/tt_accum_unit.sv
// Multi-channel accumulator with a single-entry result buffer and
// valid/ready handshakes on both command and result sides.
module tt_accum_unit
    import tt_accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          op,
    input  logic [$clog2(NCH)-1:0]   ch,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_ovf
);

    localparam int CHW = $clog2(NCH);

    logic [WIDTH-1:0] acc_q [NCH];
    state_e           state_q, state_d;
    logic [CHW-1:0]   out_ch_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_ovf_q;
    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    assign in_ready = ena && ((state_q == ST_EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;

    tt_accum_alu #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_alu (
        .acc    (acc_q[ch]),
        .a      (a),
        .b      (b),
        .op     (op_e'(op)),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (accept) begin
            acc_q[ch] <= alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_ch_q   <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else if (accept) begin
            out_ch_q   <= ch;
            out_data_q <= alu_result;
            out_ovf_q  <= alu_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // With the block disabled out_ready is ignored, so the buffer cannot drain.
    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_FULL;
                ST_FULL:  if (!accept && out_ready) state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
        out_ch    = out_ch_q;
        out_data  = out_data_q;
        out_ovf   = out_ovf_q;
    end

endmodule

// File: doc/tt_accum_unit.md
TT_ACCUM_UNIT -- requirements
Module: tt_accum_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand, accumulator and result width in bits (4..16).
REQ-002 SHALL have parameter NCH, default 4: number of independent accumulator channels (power of 2, 2..16).
REQ-003 SHALL have parameter SAT, default 1: 1 = saturating arithmetic, 0 = modulo-2^WIDTH wrap.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port ena, input, 1 bit: block enable; 0 freezes all state.
REQ-007 SHALL have port in_valid, input, 1 bit: command present.
REQ-008 SHALL have port in_ready, output, 1 bit: command accepted this cycle if in_valid=1.
REQ-009 SHALL have port op, input, 2 bits: command (LOAD=0, ADD=1, SUB=2, CLR=3).
REQ-010 SHALL have port ch, input, $clog2(NCH) bits: target channel.
REQ-011 SHALL have ports a and b, input, WIDTH bits each: unsigned operands.
REQ-012 SHALL have port out_valid, output, 1 bit: result buffer holds a result.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-014 SHALL have ports out_ch ($clog2(NCH) bits), out_data (WIDTH bits) and out_ovf (1 bit), outputs: channel, new accumulator value and range flag of the buffered result.

Function
REQ-015 SHALL accept a command on a rising edge where in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready = ena and (out_valid=0 or out_ready=1).
REQ-017 SHALL compute on acceptance: LOAD acc[ch]<=a; ADD acc[ch]<=acc[ch]+a+b; SUB acc[ch]<=acc[ch]-a; CLR acc[ch]<=0.
REQ-018 SHALL evaluate ADD/SUB at WIDTH+2 bits; a true result above 2^WIDTH-1 or below 0 is out of range.
REQ-019 SHALL, when SAT=1 and out of range, clamp to 2^WIDTH-1 (overflow) or 0 (underflow); when SAT=0, keep the low WIDTH bits.
REQ-020 SHALL set out_ovf=1 exactly when the true result is out of range, in either mode; LOAD and CLR give out_ovf=0.
REQ-021 SHALL present the result with one-cycle latency: out_valid=1 and out_ch/out_data/out_ovf valid on the edge after acceptance.
REQ-022 SHALL implement a two-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-023 SHALL transition EMPTY->FULL on acceptance, FULL->EMPTY on out_ready without acceptance, and stay FULL with the new result on simultaneous out_ready and acceptance.
REQ-024 SHALL hold out_ch, out_data and out_ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL let back-to-back commands to one channel see the updated value with no bubble.
REQ-026 SHALL leave non-target channels unchanged.
REQ-027 SHALL, when ena=0, accept nothing and change no state; out_ready is ignored.

Reset
REQ-028 SHALL on rst=1 clear all accumulators to 0 and force EMPTY, regardless of ena or any in-flight command.
REQ-029 SHALL drive out_valid=0, out_ch=0, out_data=0 and out_ovf=0 from the edge on which rst=1 is sampled; in_ready then follows REQ-016.
REQ-030 SHALL give rst priority over a command presented in the same cycle; that command is dropped.

Structure
REQ-031 SHALL place the op encoding enum, the FSM state enum and the OP width constant in package tt_accum_pkg.
REQ-032 SHALL use one combinational sub-module tt_accum_alu (acc, a, b, op, SAT -> result, ovf).
REQ-033 SHALL hold accumulators in a flop array of NCH x WIDTH; no memory macros.

Verification (WIDTH=8, NCH=4)
REQ-034 SHALL cover: rst for 1 cycle -> out_valid=0, out_data=0x00, out_ovf=0; in_ready=1 with ena=1.
REQ-035 SHALL cover: LOAD ch1 a=0x10, then ADD ch1 a=0x20 b=0x05 -> results 0x10 then 0x35, ovf=0, ch0/2/3 unchanged.
REQ-036 SHALL cover: LOAD ch2 0xF0, then ADD a=0x20 b=0x00 -> SAT=1: 0xFF ovf=1; SAT=0: 0x10 ovf=1.
REQ-037 SHALL cover: acc ch0=0x05, SUB a=0x10 -> SAT=1: 0x00 ovf=1; SAT=0: 0xF5 ovf=1.
REQ-038 SHALL cover: out_ready=0 with FULL -> in_ready=0 and outputs stable for 5 cycles; then out_ready=1 with in_valid=1 -> new result next edge, out_valid stays 1.
REQ-039 SHALL cover: rst asserted while FULL and in_valid=1 -> out_valid=0, all accumulators 0, command dropped.
